deser_rx: RTL and testbench

//  Serial-to-parallel receiver; counterpart of the ds_40/ds_160 parallel-to-serial blocks.

---
 rtl/deser_pkg.sv | 13 +
 rtl/deser_frame_cnt.sv | 39 +++
 rtl/deser_rx.sv | 152 +++++++++++++++
 tb/tb_deser_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the deser_rx serial receiver.
package deser_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'hBC;

  // Even parity of a word zero-extended to 32 bits; padding does not change XOR.
  function automatic logic even_par(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/deser_frame_cnt.sv
// Bit-position counter for deser_rx: wrap pulse at the end of each frame and a flag
// marking the trailing parity slot when parity framing is enabled.
module deser_frame_cnt #(
  parameter int WIDTH  = 8,
  parameter bit PAR_EN = 1'b0
) (
  input  logic clock_40,
  input  logic reset,
  input  logic enable,
  input  logic run,
  input  logic restart,
  output logic wrap,
  output logic par_slot
);

  localparam int CW    = $clog2(WIDTH + 1);
  localparam int LAST  = PAR_EN ? WIDTH : WIDTH - 1;
  // With parity, a sync caught while hunting still owes its parity bit, so restart there.
  localparam int START = PAR_EN ? WIDTH : 0;

  logic [CW-1:0] bitcnt_q, bitcnt_d;

  assign wrap     = enable && run && (bitcnt_q == CW'(LAST));
  assign par_slot = PAR_EN && (bitcnt_q == CW'(WIDTH));

  always_comb begin
    bitcnt_d = '0;
    if (enable) begin
      if (restart)           bitcnt_d = CW'(START);
      else if (run && !wrap) bitcnt_d = bitcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock_40 or posedge reset) begin
    if (reset) bitcnt_q <= '0;
    else       bitcnt_q <= bitcnt_d;
  end

endmodule

// File: rtl/deser_rx.sv
// Serial-to-parallel receiver: hunts a sync word, locks after LOCK_COUNT in-frame syncs,
// then strobes out words. Define DESER_PARITY_EN for a trailing even-parity bit per word.
module deser_rx
  import deser_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(DEFAULT_SYNC),
  parameter int               LOCK_COUNT = 3
) (
  input  logic             clock_40,
  input  logic             reset,
  input  logic             enable,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             locked,
  output logic             align_err
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int SCW = $clog2(LOCK_COUNT + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [SCW-1:0]   synccnt_q, synccnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             align_err_q, align_err_d;
  logic             locked_q, locked_d;
`ifdef DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0] nsr, word;
  logic             wrap, par_slot, par_ok, restart, run;

  assign nsr    = {sr_q[WIDTH-2:0], data_in};
  // In the parity slot the completed word is already in sr; data_in is its parity bit.
  assign word   = par_slot ? sr_q : nsr;
  assign par_ok = !par_slot || (data_in == even_par(32'(sr_q)));
  assign run    = (state_q != HUNT);

  deser_frame_cnt #(.WIDTH(WIDTH), .PAR_EN(PAR_EN)) u_frame_cnt (
    .clock_40 (clock_40),
    .reset    (reset),
    .enable   (enable),
    .run      (run),
    .restart  (restart),
    .wrap     (wrap),
    .par_slot (par_slot)
  );

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    synccnt_d    = synccnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    align_err_d  = 1'b0;
    restart      = 1'b0;
`ifdef DESER_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (!enable) begin
      state_d   = HUNT;
      synccnt_d = '0;
    end else begin
      sr_d = nsr;
      unique case (state_q)
        HUNT: begin
          if (nsr == SYNC_WORD) begin
            restart = 1'b1;
`ifdef DESER_PARITY_EN
            // This sync is only counted once its parity slot checks out.
            state_d   = VERIFY;
            synccnt_d = '0;
`else
            synccnt_d = SCW'(1);
            state_d   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
`endif
          end
        end
        VERIFY: begin
          if (wrap) begin
            if ((word == SYNC_WORD) && par_ok) begin
              synccnt_d = synccnt_q + SCW'(1);
              if (synccnt_d == SCW'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              state_d     = HUNT;
              synccnt_d   = '0;
              align_err_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (wrap && (word != SYNC_WORD)) begin
            data_out_d   = word;
            data_valid_d = 1'b1;
`ifdef DESER_PARITY_EN
            parity_err_d = !par_ok;
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock_40 or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      synccnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      locked_q     <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      synccnt_q    <= synccnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      align_err_q  <= align_err_d;
      locked_q     <= locked_d;
`ifdef DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign align_err  = align_err_q;
  assign locked     = locked_q;
`ifdef DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_deser_rx.sv
// Randomized self-checking bench for deser_rx against a window/alignment reference model.
module tb_deser_rx;

  localparam int         W    = 8;
  localparam int         LC   = 3;
  localparam logic [7:0] SYNC = 8'hBC;
  localparam int         MASK = (1 << W) - 1;

  logic         clock_40 = 1'b0;
  logic         reset    = 1'b1;
  logic         enable   = 1'b0;
  logic         data_in  = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, locked, align_err;
`ifdef DESER_PARITY_EN
  logic         parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sliding window of the last W enabled bits plus frame bookkeeping.
  int           win, since, good;
  bit           framed;
  logic [W-1:0] m_data;
  logic         m_valid, m_align, m_locked;

  wire [10:0] obs  = {locked, data_valid, align_err, data_out};
  wire [10:0] expv = {m_locked, m_valid, m_align, m_data};

  deser_rx #(.WIDTH(W), .SYNC_WORD(SYNC), .LOCK_COUNT(LC)) dut (
    .clock_40   (clock_40),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .align_err  (align_err)
`ifdef DESER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock_40 = ~clock_40;

  task automatic model_reset();
    win = 0; since = 0; good = 0; framed = 0;
    m_data = '0; m_valid = 0; m_align = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit en, input bit b);
    m_valid = 0;
    m_align = 0;
    if (!en) begin
      framed = 0;
      good   = 0;
    end else begin
      win = ((win << 1) | int'(b)) & MASK;
      if (!framed) begin
        if (win == int'(SYNC)) begin
          framed = 1; good = 1; since = 0;
        end
      end else begin
        since = since + 1;
        if (since == W) begin
          since = 0;
          if (good >= LC) begin
            if (win != int'(SYNC)) begin
              m_data  = win[W-1:0];
              m_valid = 1;
            end
          end else if (win == int'(SYNC)) begin
            good = good + 1;
          end else begin
            framed = 0; good = 0; m_align = 1;
          end
        end
      end
    end
    m_locked = framed && (good >= LC);
  endtask

  // Drive one cycle and sample 1 ns after the edge.
  task automatic step(input bit en, input bit b);
    enable  = en;
    data_in = b;
    @(posedge clock_40);
    model_step(en, b);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; data_in = 0;
    model_reset();
    @(posedge clock_40);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    bit b;
    reset = 1; enable = 0; data_in = 0;
    model_reset();
    repeat (2) @(posedge clock_40);
    #1;
    n_cmp++;
    if (obs !== 11'h0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs, 11'h0);
    end
`ifdef DESER_PARITY_EN
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err);
    end
`endif
    reset = 0;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      if ((((win << 1) | int'(b)) & MASK) == int'(SYNC)) b = ~b;
      step(1, b);
      n_cmp++;
      if (obs !== expv || data_valid !== 1'b0 || locked !== 1'b0) begin
        n_bad++; $display("FAIL nosync_stream[%0d]: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] words[4] = '{SYNC, SYNC, SYNC, 8'h5A};
    int         strobes = 0;
    logic [7:0] last = '0;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      step(1, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL lock_junk[%0d]: got %h want %h", j, obs, expv);
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        step(1, words[k][i]);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL lock_seq[%0d.%0d]: got %h want %h", k, i, obs, expv);
        end
        if (k == 2 && i == 1) begin
          n_cmp++;
          if (locked !== 1'b0) begin
            n_bad++; $display("FAIL lock_early: got %b want 0", locked);
          end
        end
        if (k == 2 && i == 0) begin
          n_cmp++;
          if (locked !== 1'b1) begin
            n_bad++; $display("FAIL lock_rise: got %b want 1", locked);
          end
        end
        if (data_valid === 1'b1) begin strobes++; last = data_out; end
      end
    end
    n_cmp++;
    if (strobes !== 1 || last !== 8'h5A) begin
      n_bad++; $display("FAIL lock_word: got %0d strobes data %h want 1 strobe data 5a", strobes, last);
    end
  endtask

  task automatic test_swallow();
    logic [7:0] words[2] = '{SYNC, 8'h11};
    int         strobes = 0;
    logic [7:0] last = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        step(1, words[k][i]);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL swallow_seq[%0d.%0d]: got %h want %h", k, i, obs, expv);
        end
        if (data_valid === 1'b1) begin strobes++; last = data_out; end
      end
    end
    n_cmp++;
    if (strobes !== 1 || last !== 8'h11 || locked !== 1'b1) begin
      n_bad++; $display("FAIL swallow_word: got %0d strobes data %h locked %b want 1 strobe data 11 locked 1",
                        strobes, last, locked);
    end
  endtask

  task automatic test_align();
    logic [7:0] words[3] = '{SYNC, SYNC, 8'h3C};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        step(1, words[k][i]);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL align_seq[%0d.%0d]: got %h want %h", k, i, obs, expv);
        end
        if (k == 2 && i == 0) begin
          n_cmp++;
          if (align_err !== 1'b1 || locked !== 1'b0) begin
            n_bad++; $display("FAIL align_pulse: got err %b locked %b want err 1 locked 0", align_err, locked);
          end
        end
      end
    end
    step(1, 1'b0);
    n_cmp++;
    if (align_err !== 1'b0 || obs !== expv) begin
      n_bad++; $display("FAIL align_single: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] words[4] = '{SYNC, SYNC, SYNC, 8'h5A};
    int         strobes = 0;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = W - 1; i >= 0; i--) step(1, words[k][i]);
    for (int i = 0; i < 4; i++) step(1, 1'($urandom_range(0, 1)));
    n_cmp++;
    if (locked !== 1'b1 || data_out !== 8'h5A) begin
      n_bad++; $display("FAIL drop_prelock: got locked %b data %h want 1 5a", locked, data_out);
    end
    step(0, 1'b0);
    n_cmp++;
    if (locked !== 1'b0 || obs !== expv) begin
      n_bad++; $display("FAIL drop_unlock: got %h want %h", obs, expv);
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 1'($urandom_range(0, 1)));
      if (data_valid === 1'b1) strobes++;
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL drop_after[%0d]: got %h want %h", i, obs, expv);
      end
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_bad++; $display("FAIL drop_nostrobe: got %0d strobes want 0", strobes);
    end
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = W - 1; i >= 0; i--) step(1, words[k][i]);
    for (int i = 0; i < 3; i++) step(1, 1'b1);
    #2 reset = 1;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== 11'h0) begin
      n_bad++; $display("FAIL reset_midword: got %h want %h", obs, 11'h0);
    end
    @(posedge clock_40);
    #1 reset = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    do_reset();
    for (int k = 0; k < 63; k++) begin
      w = (k < 3 || $urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      for (int i = W - 1; i >= 0; i--) begin
        if ($urandom_range(0, 49) == 0) begin
          step(0, 1'($urandom_range(0, 1)));
          n_cmp++;
          if (obs !== expv) begin
            n_bad++; $display("FAIL b2b_gap[%0d.%0d]: got %h want %h", k, i, obs, expv);
          end
        end
        step(1, w[i]);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL b2b[%0d.%0d]: got %h want %h", k, i, obs, expv);
        end
      end
    end
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    logic [8:0] fr[5] = '{{SYNC, 1'b1}, {SYNC, 1'b1}, {SYNC, 1'b1}, {8'hA5, 1'b1}, {8'h5A, 1'b0}};
    int strobes = 0;
    do_reset();
    for (int j = 0; j < 3; j++) step(1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = W; i >= 0; i--) begin
        step(1, fr[k][i]);
        if (data_valid === 1'b1) strobes++;
        if (k == 2 && i == 0) begin
          n_cmp++;
          if (locked !== 1'b1) begin
            n_bad++; $display("FAIL par_lock: got %b want 1", locked);
          end
        end
        if (k == 3 && i == 0) begin
          n_cmp++;
          if ({data_valid, parity_err, data_out} !== {1'b1, 1'b1, 8'hA5}) begin
            n_bad++; $display("FAIL par_bad: got v%b p%b %h want v1 p1 a5", data_valid, parity_err, data_out);
          end
        end
        if (k == 4 && i == 0) begin
          n_cmp++;
          if ({data_valid, parity_err, data_out} !== {1'b1, 1'b0, 8'h5A}) begin
            n_bad++; $display("FAIL par_good: got v%b p%b %h want v1 p0 5a", data_valid, parity_err, data_out);
          end
        end
      end
    end
    n_cmp++;
    if (strobes !== 2) begin
      n_bad++; $display("FAIL par_strobes: got %0d want 2", strobes);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DESER_PARITY_EN
    test_parity();
`else
    test_lock();
    test_swallow();
    test_align();
    test_enable_drop();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
